// File: rtl/pipeline_mem.sv
// MEM stage of the 5-stage RV32I pipeline.
// Registers EX results toward WB and the MEM forwarding path.
// Loads and stores go one byte per cycle over an 8-bit synchronous data-memory port.
// Load bytes are assembled little-endian and then sign- or zero-extended.
// While a multi-byte access is in flight, the stage raises stall_o so IF/ID/EX hold.
//
// Memory port protocol: ram_a_o, ram_wr_o and ram_dout_o are combinational.
// A write takes effect on the rising edge that ends the cycle in which ram_wr_o is high.
// Read data for an address driven in cycle t appears on ram_din_i in cycle t+1.
// There is no valid/ready handshake on the EX side. A request is consumed only in IDLE.
// In LOAD and STORE, the EX inputs are ignored, and stall_o asks upstream to hold.
module pipeline_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  mre_i,
    input  logic        mrsign_i,
    input  logic [1:0]  mwe_i,
    input  logic [31:0] mwdata_i,
    input  logic [31:0] ma_i,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    // The current state is kept as a named, typed signal so checkers can bind to it.
    state_t      state;
    state_t      state_n;

    // Access context, latched when a request is accepted.
    logic [4:0]  rd_q;
    logic [1:0]  size_q;     // the access size, for both a load and a store
    logic        sign_q;
    logic [31:0] ma_q;
    logic [31:0] mwdata_q;
    logic [2:0]  cnt;        // number of byte addresses issued so far
    logic [23:0] byte_buf;   // load bytes 0..2; the last byte comes straight off ram_din_i

    logic [2:0]  len_q;
    logic [31:0] load_val;
    logic [7:0]  store_byte;

    // Converts a size code to a byte count: 01 -> 1, 10 -> 2, 11 -> 4.
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b01:   size_bytes = 3'd1;
            2'b10:   size_bytes = 3'd2;
            2'b11:   size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    assign len_q = size_bytes(size_q);

    // Selects the latched store byte for the current beat.
    always_comb begin
        store_byte = 8'h00;
        case (cnt[1:0])
            2'd0:    store_byte = mwdata_q[7:0];
            2'd1:    store_byte = mwdata_q[15:8];
            2'd2:    store_byte = mwdata_q[23:16];
            default: store_byte = mwdata_q[31:24];
        endcase
    end

    // Assembles the final load value from the buffered bytes and the last byte in flight.
    always_comb begin
        load_val = 32'h0;
        case (size_q)
            2'b01: load_val = {{24{sign_q & ram_din_i[7]}}, ram_din_i};
            2'b10: load_val = {{16{sign_q & ram_din_i[7]}}, ram_din_i, byte_buf[7:0]};
            2'b11: load_val = {ram_din_i, byte_buf};
            default: load_val = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Computes the next state and drives the memory port and stall request.
    // In IDLE, a load takes priority over a store.
    // While reset is high, the port and the stall request are forced idle.
    always_comb begin
        state_n    = state;
        ram_a_o    = 32'h0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'h00;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (mre_i != 2'b00) begin
                    state_n = LOAD;
                    ram_a_o = ma_i;
                    stall_o = 1'b1;
                end else if (mwe_i != 2'b00) begin
                    ram_a_o    = ma_i;
                    ram_wr_o   = 1'b1;
                    ram_dout_o = mwdata_i[7:0];
                    // A byte store finishes in its own cycle, so it never stalls.
                    if (size_bytes(mwe_i) != 3'd1) begin
                        state_n = STORE;
                        stall_o = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cnt == len_q) begin
                    // This cycle only collects the last byte. The port is idle.
                    state_n = IDLE;
                end else begin
                    ram_a_o = ma_q + {29'd0, cnt};
                    stall_o = 1'b1;
                end
            end
            STORE: begin
                ram_a_o    = ma_q + {29'd0, cnt};
                ram_wr_o   = 1'b1;
                ram_dout_o = store_byte;
                if (cnt == len_q - 3'd1) begin
                    state_n = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            ram_a_o    = 32'h0;
            ram_wr_o   = 1'b0;
            ram_dout_o = 8'h00;
            stall_o    = 1'b0;
        end
    end

    // Updates the access context, byte counter and load buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= 5'd0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            ma_q     <= 32'h0;
            mwdata_q <= 32'h0;
            cnt      <= 3'd0;
            byte_buf <= 24'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mre_i != 2'b00) begin
                        rd_q     <= rd_i;
                        size_q   <= mre_i;
                        sign_q   <= mrsign_i;
                        ma_q     <= ma_i;
                        cnt      <= 3'd1;
                        byte_buf <= 24'h0;
                    end else if (mwe_i != 2'b00) begin
                        size_q   <= mwe_i;
                        ma_q     <= ma_i;
                        mwdata_q <= mwdata_i;
                        cnt      <= 3'd1;
                    end
                end
                LOAD: begin
                    if (cnt == len_q) begin
                        cnt <= 3'd0;
                    end else begin
                        // ram_din_i holds the byte addressed in the previous cycle, i.e. byte cnt-1.
                        case (cnt)
                            3'd1:    byte_buf[7:0]   <= ram_din_i;
                            3'd2:    byte_buf[15:8]  <= ram_din_i;
                            3'd3:    byte_buf[23:16] <= ram_din_i;
                            default: byte_buf        <= byte_buf;
                        endcase
                        cnt <= cnt + 3'd1;
                    end
                end
                STORE: begin
                    if (cnt == len_q - 3'd1) begin
                        cnt <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: cnt <= 3'd0;
            endcase
        end
    end

    // Writes the WB/forwarding registers.
    // A pass-through op copies the EX values. A completed load writes its result.
    // Every other edge writes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_o    <= 5'd0;
            we_o    <= 1'b0;
            wdata_o <= 32'h0;
        end else begin
            rd_o    <= 5'd0;
            we_o    <= 1'b0;
            wdata_o <= 32'h0;
            if (state == IDLE && mre_i == 2'b00 && mwe_i == 2'b00) begin
                rd_o    <= rd_i;
                we_o    <= we_i;
                wdata_o <= wdata_i;
            end else if (state == LOAD && cnt == len_q) begin
                rd_o    <= rd_q;
                we_o    <= 1'b1;
                wdata_o <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for the MEM stage.
// Applies a table of directed ops, hand-built sequences for back-to-back and mid-access reset,
// and random ops checked against a transaction-level memory model.
module tb_pipeline_mem;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  mre;
        logic        mrsign;
        logic [1:0]  mwe;
        logic [31:0] mwdata;
        logic [31:0] ma;
    } op_t;

    typedef struct {
        op_t         op;
        logic [4:0]  erd;
        logic        ewe;
        logic [31:0] ewd;
        int          estall;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [1:0]  mre_i;
    logic        mrsign_i;
    logic [1:0]  mwe_i;
    logic [31:0] mwdata_i;
    logic [31:0] ma_i;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic [4:0]  rd_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;

    // dmem is the memory the DUT actually talks to.
    // ref_mem is what the memory should contain according to the model.
    logic [7:0] dmem    [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    pipeline_mem dut (
        .clk        (clk),
        .rst        (rst),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .wdata_i    (wdata_i),
        .mre_i      (mre_i),
        .mrsign_i   (mrsign_i),
        .mwe_i      (mwe_i),
        .mwdata_i   (mwdata_i),
        .ma_i       (ma_i),
        .ram_a_o    (ram_a_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i),
        .rd_o       (rd_o),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .stall_o    (stall_o)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background contents for bytes that were never written.
    function automatic logic [7:0] dflt(input logic [31:0] a);
        dflt = a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dmem_rd(input logic [31:0] a);
        if (dmem.exists(a)) dmem_rd = dmem[a];
        else dmem_rd = dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) ref_rd = ref_mem[a];
        else ref_rd = dflt(a);
    endfunction

    // Synchronous byte memory. Writes land on the edge; read data follows one cycle after its address.
    always @(posedge clk) begin
        if (ram_wr_o) dmem[ram_a_o] = ram_dout_o;
        ram_din_i <= dmem_rd(ram_a_o);
    end

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b01:   nbytes = 1;
            2'b10:   nbytes = 2;
            2'b11:   nbytes = 4;
            default: nbytes = 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input op_t op);
        rd_i     = op.rd;
        we_i     = op.we;
        wdata_i  = op.wdata;
        mre_i    = op.mre;
        mrsign_i = op.mrsign;
        mwe_i    = op.mwe;
        mwdata_i = op.mwdata;
        ma_i     = op.ma;
    endtask

    function automatic op_t idle_op();
        op_t o;
        o = '{rd: 5'd0, we: 1'b0, wdata: 32'h0, mre: 2'b00, mrsign: 1'b0,
              mwe: 2'b00, mwdata: 32'h0, ma: 32'h0};
        return o;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) rand_addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
        else rand_addr = 32'h0000_1000 + $urandom_range(0, 15);
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  kind;
        kind     = $urandom_range(0, 2);
        o.rd     = 5'($urandom);
        o.we     = 1'($urandom);
        o.wdata  = $urandom;
        o.mrsign = 1'($urandom);
        o.mwdata = $urandom;
        o.ma     = rand_addr();
        o.mre    = 2'b00;
        o.mwe    = 2'b00;
        if (kind == 1) begin
            o.mre = 2'($urandom_range(1, 3));
            o.mwe = 2'($urandom_range(0, 3));  // a load beats a simultaneous store
        end else if (kind == 2) begin
            o.mwe = 2'($urandom_range(1, 3));
        end
        return o;
    endfunction

    // Applies one op and checks every cycle it occupies.
    // After the first cycle, the inputs carry busy_op, or random junk, which the DUT must ignore.
    task automatic run_op(input op_t op, input logic [4:0] erd, input logic ewe,
                          input logic [31:0] ewd, input int nstall, input op_t busy_op,
                          input bit rand_busy, input string name);
        bit          is_ld;
        bit          is_st;
        int          n;
        int          d;
        logic [31:0] exp_a;
        logic [31:0] sh;
        is_ld = (op.mre != 2'b00);
        is_st = !is_ld && (op.mwe != 2'b00);
        n     = is_ld ? nbytes(op.mre) : (is_st ? nbytes(op.mwe) : 0);
        d     = is_ld ? n + 1 : (is_st ? n : 1);
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (k == 0) drive(op);
            else if (rand_busy) drive(rand_op());
            else drive(busy_op);
            #1;
            chk({name, ".stall"}, 32'(stall_o), 32'(k < nstall));
            if (is_ld) begin
                exp_a = (k < n) ? op.ma + 32'(k) : 32'h0;
                chk({name, ".addr"}, ram_a_o, exp_a);
                chk({name, ".wr"}, 32'(ram_wr_o), 32'h0);
            end else if (is_st) begin
                sh = op.mwdata >> (8 * k);
                chk({name, ".addr"}, ram_a_o, op.ma + 32'(k));
                chk({name, ".wr"}, 32'(ram_wr_o), 32'h1);
                chk({name, ".dout"}, 32'(ram_dout_o), {24'h0, sh[7:0]});
            end else begin
                chk({name, ".addr"}, ram_a_o, 32'h0);
                chk({name, ".wr"}, 32'(ram_wr_o), 32'h0);
            end
            @(posedge clk);
            #1;
            if (k < d - 1) begin
                chk({name, ".bubble_rd"}, 32'(rd_o), 32'h0);
                chk({name, ".bubble_we"}, 32'(we_o), 32'h0);
                chk({name, ".bubble_wdata"}, wdata_o, 32'h0);
            end else begin
                chk({name, ".rd"}, 32'(rd_o), 32'(erd));
                chk({name, ".we"}, 32'(we_o), 32'(ewe));
                chk({name, ".wdata"}, wdata_o, ewd);
            end
        end
    endtask

    // Transaction-level model.
    // Returns the expected WB values and stall length, and updates ref_mem for stores.
    task automatic model(input op_t op, output logic [4:0] erd, output logic ewe,
                         output logic [31:0] ewd, output int nstall);
        int          n;
        logic [63:0] v;
        if (op.mre != 2'b00) begin
            n = nbytes(op.mre);
            v = 64'h0;
            for (int k = 0; k < n; k++) v = v | (64'(ref_rd(op.ma + 32'(k))) << (8 * k));
            if (op.mrsign && v[8 * n - 1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
            erd    = op.rd;
            ewe    = 1'b1;
            ewd    = v[31:0];
            nstall = n;
        end else if (op.mwe != 2'b00) begin
            n = nbytes(op.mwe);
            v = 64'(op.mwdata);
            for (int k = 0; k < n; k++) ref_mem[op.ma + 32'(k)] = 8'(v >> (8 * k));
            erd    = 5'd0;
            ewe    = 1'b0;
            ewd    = 32'h0;
            nstall = n - 1;
        end else begin
            erd    = op.rd;
            ewe    = op.we;
            ewd    = op.wdata;
            nstall = 0;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        dmem[a]    = b;
        ref_mem[a] = b;
    endtask

    vec_t        vecs[8];
    op_t         o;
    op_t         alu;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [31:0] m_wd;
    int          m_st;

    initial begin
        // Reset block.
        rst = 1'b1;
        drive(idle_op());
        ram_din_i = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = idle_op();
        o.mre = 2'b11;
        o.ma  = 32'h55;
        drive(o);
        #1;
        chk("reset.stall", 32'(stall_o), 32'h0);
        chk("reset.wr", 32'(ram_wr_o), 32'h0);
        chk("reset.rd", 32'(rd_o), 32'h0);
        chk("reset.we", 32'(we_o), 32'h0);
        chk("reset.wdata", wdata_o, 32'h0);
        @(negedge clk);
        drive(idle_op());
        rst = 1'b0;

        preload(32'h100, 8'h80);
        preload(32'h202, 8'h34);
        preload(32'h203, 8'h92);

        // Directed table.
        // Fields: rd, we, wdata, mre, mrsign, mwe, mwdata, ma; then the expected rd, we, wdata and stall length.
        vecs[0] = '{'{5'd5, 1'b1, 32'h1234, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0},
                    5'd5, 1'b1, 32'h0000_1234, 0, "alu_pass"};
        vecs[1] = '{'{5'd3, 1'b0, 32'hAAAA, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0},
                    5'd3, 1'b0, 32'h0000_AAAA, 0, "alu_nowe"};
        vecs[2] = '{'{5'd1, 1'b0, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 32'h100},
                    5'd1, 1'b1, 32'hFFFF_FF80, 1, "lb_signed"};
        vecs[3] = '{'{5'd2, 1'b1, 32'h0, 2'b10, 1'b0, 2'b00, 32'h0, 32'h202},
                    5'd2, 1'b1, 32'h0000_9234, 2, "lhu"};
        vecs[4] = '{'{5'd4, 1'b1, 32'h0, 2'b10, 1'b1, 2'b11, 32'h0, 32'h202},
                    5'd4, 1'b1, 32'hFFFF_9234, 2, "lh_signed"};
        vecs[5] = '{'{5'd6, 1'b1, 32'h9, 2'b00, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFE},
                    5'd0, 1'b0, 32'h0, 3, "sw_wrap"};
        vecs[6] = '{'{5'd8, 1'b1, 32'h9, 2'b00, 1'b0, 2'b01, 32'h0000_0077, 32'h400},
                    5'd0, 1'b0, 32'h0, 0, "sb"};
        vecs[7] = '{'{5'd10, 1'b1, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h400},
                    5'd10, 1'b1, 32'h0000_0077, 1, "lbu_after_sb"};

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].erd, vecs[i].ewe, vecs[i].ewd, vecs[i].estall,
                   idle_op(), 1'b1, vecs[i].name);
            if (vecs[i].op.mre == 2'b00 && vecs[i].op.mwe != 2'b00)
                model(vecs[i].op, m_rd, m_we, m_wd, m_st);
        end

        // A word load is held back-to-back with an ALU op waiting behind the stall.
        // The load reads back the wrapped word written by the sw_wrap vector.
        o = idle_op();
        o.rd  = 5'd7;
        o.mre = 2'b11;
        o.ma  = 32'hFFFF_FFFE;
        alu = idle_op();
        alu.rd    = 5'd9;
        alu.we    = 1'b1;
        alu.wdata = 32'h55AA;
        run_op(o, 5'd7, 1'b1, 32'hDEAD_BEEF, 4, alu, 1'b0, "lw_then_alu");
        run_op(alu, 5'd9, 1'b1, 32'h0000_55AA, 0, idle_op(), 1'b0, "alu_after_lw");

        // Reset arrives in the third cycle of a word store.
        o = idle_op();
        o.mwe    = 2'b11;
        o.mwdata = 32'hCAFE_F00D;
        o.ma     = 32'h3000;
        @(negedge clk);
        drive(o);
        @(negedge clk);
        drive(idle_op());
        @(negedge clk);
        #1;
        chk("rst_mid.pre_wr", 32'(ram_wr_o), 32'h1);
        chk("rst_mid.pre_addr", ram_a_o, 32'h3002);
        rst = 1'b1;
        #1;
        chk("rst_mid.wr", 32'(ram_wr_o), 32'h0);
        chk("rst_mid.stall", 32'(stall_o), 32'h0);
        chk("rst_mid.rd", 32'(rd_o), 32'h0);
        chk("rst_mid.we", 32'(we_o), 32'h0);
        chk("rst_mid.wdata", wdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[32'h3000] = 8'h0D;
        ref_mem[32'h3001] = 8'hF0;
        // A fresh store must start at byte 0.
        o = idle_op();
        o.mwe    = 2'b10;
        o.mwdata = 32'h0000_1357;
        o.ma     = 32'h3010;
        model(o, m_rd, m_we, m_wd, m_st);
        run_op(o, m_rd, m_we, m_wd, m_st, idle_op(), 1'b1, "after_rst_sh");
        o = idle_op();
        o.rd  = 5'd12;
        o.mre = 2'b11;
        o.ma  = 32'h3000;
        model(o, m_rd, m_we, m_wd, m_st);
        run_op(o, m_rd, m_we, m_wd, m_st, idle_op(), 1'b1, "partial_store_lw");

        // Random ops against the model.
        for (int i = 0; i < 200; i++) begin
            o = rand_op();
            model(o, m_rd, m_we, m_wd, m_st);
            run_op(o, m_rd, m_we, m_wd, m_st, idle_op(), 1'b1, "rand");
        end

        // Final report.
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_mem.md
Name: pipeline_mem

Overview:
MEM stage of the 5-stage RV32I pipeline, directly downstream of EX and upstream of WB. Registers EX results, performs byte-serial loads and stores on an 8-bit synchronous data-memory port, and assembles and sign-extends load data. Stalls IF/ID/EX while a multi-byte access is in flight. Its registered outputs drive WB and the EX-stage MEM forwarding path.

Parameters:
None. Widths come from the shared bus macros: DataBus 32, RegAddrBus 5, MemAddrBus 32.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_i  in  5  destination register from EX
we_i  in  1  register write enable from EX
wdata_i  in  32  ALU/link result from EX
mre_i  in  2  load size: 00 none, 01 byte, 10 half, 11 word
mrsign_i  in  1  1 = sign-extend load result
mwe_i  in  2  store size, same encoding as mre_i
mwdata_i  in  32  store data
ma_i  in  32  byte address of the access
ram_a_o  out  32  data-memory byte address (combinational)
ram_wr_o  out  1  data-memory write strobe (combinational)
ram_dout_o  out  8  store byte (combinational)
ram_din_i  in  8  read byte; valid 1 cycle after its address
rd_o  out  5  registered destination to WB and forwarding
we_o  out  1  registered write enable
wdata_o  out  32  registered result
stall_o  out  1  stall request (combinational) for stages 0..3

Behaviour:
- Access size N: byte 1, half 2, word 4. Little-endian; byte k uses address ma+k, modulo 2^32.
- Request: in IDLE, mre_i != 0 starts a load. Otherwise mwe_i != 0 starts a store. Load wins if both are nonzero.
- FSM states: IDLE, LOAD, STORE.
- Registers: latched rd, mre, mrsign, ma, mwdata; 3-bit counter cnt; 24-bit byte buffer.
- Non-memory op (IDLE, no request):
  - rd_o/we_o/wdata_o <= rd_i/we_i/wdata_i on the next edge. 1-cycle latency, stall_o=0.
  - ram_wr_o=0, ram_a_o=0, ram_dout_o=0.
- Load, accepted in cycle T:
  - Address ma+k is driven in cycle T+k, for k = 0..N-1.
  - ram_din_i is sampled at the end of cycle T+k+1 as byte k.
  - State goes IDLE→LOAD at the end of T. cnt counts issued addresses.
  - stall_o=1 in cycles T..T+N-1 and 0 in T+N.
  - At the end of T+N: wdata_o = assembled value, extended per mrsign to 32 bits (byte: from bit 7, half: from bit 15). rd_o = latched rd, we_o=1, state→IDLE.
  - During T+N, stall_o is 0 and ram_a_o/ram_wr_o are idle; a new request in T+N is not accepted until IDLE.
- Store, accepted in cycle T:
  - Cycle T+k: ram_a_o=ma+k, ram_wr_o=1, ram_dout_o=mwdata[8k+7:8k].
  - Byte 0 comes from mwdata_i; later bytes come from the latched copy.
  - stall_o=1 in T..T+N-2; a byte store (N=1) never stalls.
  - At the end of T+N-1: rd_o=0, we_o=0, wdata_o=0, state→IDLE.
- While a multi-byte access is in progress, every non-completing edge writes a bubble: rd_o=0, we_o=0, wdata_o=0. EX inputs are ignored while in LOAD/STORE.
- Reset, including mid-access:
  - Immediately: state=IDLE, cnt=0, buffer=0, rd_o=0, we_o=0, wdata_o=0.
  - ram_wr_o=0 and stall_o=0 while rst is high. A partially written store is not resumed.
- mre/mwe value 00 on one side with a valid size on the other is normal; both 00 means pass-through.

Test Plan:
1. ALU pass-through: rd_i=5, we_i=1, wdata_i=0x1234 → next edge rd_o=5, we_o=1, wdata_o=0x1234; stall_o never asserts.
2. Signed byte load: ma_i=0x100, mre=01, mrsign=1, memory[0x100]=0x80 → ram_a_o=0x100 in T; stall_o high 1 cycle; at end of T+1 wdata_o=0xFFFFFF80.
3. Unsigned half load at 0x202: bytes 0x34, 0x92, mrsign=0 → addresses 0x202, 0x203; stall 2 cycles; wdata_o=0x00009234.
4. Word store: ma=0xFFFFFFFE, mwdata=0xDEADBEEF → writes EF, BE, AD, DE to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (address wraps); stall_o high 3 cycles; we_o=0 after completion.
5. Word load back-to-back with an ALU op held by the stall: load issues, the ALU op is accepted only in the cycle after completion. WB sees load result then ALU result in consecutive cycles, with 4 bubbles before.
6. Reset asserted during cycle T+2 of a word store → ram_wr_o drops in the same cycle, outputs clear, the next request starts a fresh access from byte 0.
